// File: rtl/joypad_controller.sv
// joypad_controller: P1/JOYP register with group select, input synchroniser, debounce and joypad interrupt
module joypad_controller #(
    parameter int          DEBOUNCE_CYCLES = 4096,
    parameter logic [15:0] P1_ADDR         = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic [1:0]  button_sel,
    input  logic [3:0]  button_data,
    output logic        int_req
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic          w_hit;
    logic          w_unused;
    logic [1:0]    r_sel;
    logic [7:0]    r_do;
    logic [3:0]    r_s1;
    logic [3:0]    r_sync;
    logic [3:0]    r_sync_prev;
    logic [3:0]    r_deb;
    logic [3:0]    r_deb_prev;
    logic [CW-1:0] r_cnt;
    logic          r_int;
    assign w_hit      = A == P1_ADDR;
    assign w_unused   = ^{Di[7:6], Di[3:0]};
    assign Do         = r_do;
    assign button_sel = r_sel;
    assign int_req    = r_int;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel       <= 2'b11;
            r_do        <= 8'hFF;
            r_s1        <= 4'hF;
            r_sync      <= 4'hF;
            r_sync_prev <= 4'hF;
            r_deb       <= 4'hF;
            r_deb_prev  <= 4'hF;
            r_cnt       <= '0;
            r_int       <= 1'b0;
        end else begin
            // reads sample the synchronised lines so a select change shows up without debounce delay
            r_do        <= (w_hit && !rd_n) ? {2'b11, r_sel, r_sync} : 8'hFF;
            r_sel       <= (w_hit && !wr_n) ? Di[5:4] : r_sel;
            r_s1        <= button_data;
            r_sync      <= r_s1;
            r_sync_prev <= r_sync;
            if (r_sync != r_sync_prev)
                r_cnt <= '0;
            else if (r_cnt != LAST)
                r_cnt <= r_cnt + CW'(1);
            else
                r_deb <= r_sync;
            r_deb_prev  <= r_deb;
            r_int       <= |(r_deb_prev & ~r_deb);
        end
    end
endmodule

// File: tb/tb_joypad_controller.sv
// tb_joypad_controller: directed test-plan steps plus random traffic checked against a window-based reference model
module tb_joypad_controller;
    localparam int DB = 8;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] A = 16'hFF00;
    logic [7:0]  Di = 8'h00;
    logic [7:0]  Do;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [1:0]  button_sel;
    logic [3:0]  button_data = 4'hF;
    logic        int_req;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          npulse = 0;
    int          last_pulse = 0;
    int          start = 0;

    joypad_controller #(.DEBOUNCE_CYCLES(DB), .P1_ADDR(16'hFF00)) dut (
        .clock(clock), .reset(reset), .A(A), .Di(Di), .Do(Do), .rd_n(rd_n), .wr_n(wr_n),
        .button_sel(button_sel), .button_data(button_data), .int_req(int_req)
    );

    always #5 clock = ~clock;

    // reference: a value is accepted once the last DB samples since reset all equal it
    logic [1:0] m_sel;
    logic [3:0] m_s1, m_sync, m_deb, m_deb_prev;
    logic [7:0] m_do;
    logic       m_int;
    logic [4:0] m_win [DB];

    function automatic logic stable(input logic [3:0] v);
        stable = 1'b1;
        for (int i = 0; i < DB; i++)
            if (m_win[i] !== {1'b1, v}) stable = 1'b0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_sel      <= 2'b11;
            m_s1       <= 4'hF;
            m_sync     <= 4'hF;
            m_deb      <= 4'hF;
            m_deb_prev <= 4'hF;
            m_do       <= 8'hFF;
            m_int      <= 1'b0;
            m_win[0]   <= 5'h1F;
            for (int i = 1; i < DB; i++) m_win[i] <= 5'h00;
        end else begin
            m_do <= (A == 16'hFF00 && !rd_n) ? {2'b11, m_sel, m_sync} : 8'hFF;
            if (A == 16'hFF00 && !wr_n) m_sel <= Di[5:4];
            m_s1   <= button_data;
            m_sync <= m_s1;
            if (stable(m_sync)) m_deb <= m_sync;
            m_deb_prev <= m_deb;
            m_int      <= |(m_deb_prev & ~m_deb);
            m_win[0]   <= {1'b1, m_sync};
            for (int i = 1; i < DB; i++) m_win[i] <= m_win[i-1];
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (int_req === 1'b1) begin
            npulse++;
            last_pulse = cyc;
        end
        chk("do", Do, m_do);
        chk("sel", {6'b0, button_sel}, {6'b0, m_sel});
        chk("int", {7'b0, int_req}, {7'b0, m_int});
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        // 1: asynchronous reset mid-cycle after putting state away from reset values
        A = 16'hFF00; Di = 8'h10; wr_n = 1'b0; rd_n = 1'b0;
        tick();
        wr_n = 1'b1;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rst_do", Do, 8'hFF);
        chk("rst_sel", {6'b0, button_sel}, 8'h03);
        chk("rst_int", {7'b0, int_req}, 8'h00);
        rd_n = 1'b1;
        tick();
        reset = 1'b1;
        npulse = 0;
        repeat (12) tick();
        chk("rst_nopulse", 8'(npulse), 8'd0);
        // 2: select and read
        Di = 8'h20; wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        chk("sel_write", {6'b0, button_sel}, 8'h02);
        rd_n = 1'b0;
        tick();
        chk("read_idle", Do, 8'hEF);
        // 3: press and hold
        button_data = 4'hE; npulse = 0; start = cyc;
        repeat (3) tick();
        chk("read_press", Do, 8'hEE);
        repeat (27) tick();
        chk("press_pulses", 8'(npulse), 8'd1);
        chk("press_lat", {7'b0, (last_pulse - start >= 10) && (last_pulse - start <= 12)}, 8'h01);
        button_data = 4'hF;
        repeat (20) tick();
        // 4: glitch shorter than the debounce window
        npulse = 0; button_data = 4'hB;
        repeat (3) tick();
        chk("read_glitch", Do, 8'hEB);
        repeat (2) tick();
        button_data = 4'hF;
        repeat (20) tick();
        chk("glitch_pulses", 8'(npulse), 8'd0);
        // 5: address decode
        rd_n = 1'b1; A = 16'hFF01; Di = 8'h10; wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        chk("miss_write", {6'b0, button_sel}, 8'h02);
        rd_n = 1'b0;
        tick();
        chk("miss_read", Do, 8'hFF);
        // simultaneous read and write returns the old select
        A = 16'hFF00; Di = 8'h10; wr_n = 1'b0;
        tick();
        wr_n = 1'b1; rd_n = 1'b1;
        chk("rw_do", Do, 8'hEF);
        chk("rw_sel", {6'b0, button_sel}, 8'h01);
        // 6: reset in the middle of the debounce
        npulse = 0; button_data = 4'h7;
        repeat (6) tick();
        #2 reset = 1'b0;
        tick();
        tick();
        chk("mid_nopulse", 8'(npulse), 8'd0);
        reset = 1'b1; npulse = 0;
        repeat (20) tick();
        chk("mid_pulses", 8'(npulse), 8'd1);
        button_data = 4'hF;
        repeat (20) tick();
        // random traffic against the reference model
        repeat (1500) begin
            if ($urandom_range(0, 11) == 0) button_data = 4'($urandom);
            A = ($urandom_range(0, 3) < 3) ? 16'hFF00 : 16'hFF00 ^ (16'h1 << $urandom_range(0, 15));
            Di = 8'($urandom);
            rd_n = 1'($urandom_range(0, 1));
            wr_n = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
